// File: rtl/conv_dezero_if.sv
// rtl/conv_dezero_if.sv - Stream bus for conv_dezero: raw activation beats in, zero-point-removed lanes out.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

interface conv_dezero_if #(
    parameter int PICTURE_NUM    = `PICTURE_NUM,
    parameter int CHANNEL_IN_NUM = 8,
    parameter int WIDTH_DATA     = `WIDTH_DATA
);
    localparam int SW = PICTURE_NUM * CHANNEL_IN_NUM * WIDTH_DATA;
    localparam int MW = SW * 2;

    logic          S_Valid;
    logic          S_Ready;
    logic [SW-1:0] S_Data;
    logic          M_Valid;
    logic          M_Ready;
    logic [MW-1:0] M_Data;
    logic          M_Last;

    modport slave (
        input  S_Valid, S_Data, M_Ready,
        output S_Ready, M_Valid, M_Data, M_Last
    );

    modport master (
        output S_Valid, S_Data, M_Ready,
        input  S_Ready, M_Valid, M_Data, M_Last
    );
endinterface

// File: rtl/conv_dezero.sv
// rtl/conv_dezero.sv - Two-stage pipeline subtracting an unsigned zero point from every activation lane.
`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module conv_dezero #(
    parameter int PICTURE_NUM    = `PICTURE_NUM,
    parameter int CHANNEL_IN_NUM = 8,
    parameter int WIDTH_DATA     = `WIDTH_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          zero_data_in,
    input  logic [15:0]         beat_num,
    conv_dezero_if.slave        bus,
    output logic                done
);
    localparam int LANES = PICTURE_NUM * CHANNEL_IN_NUM;
    localparam int W     = WIDTH_DATA;
    localparam int SW    = LANES * W;
    localparam int MW    = SW * 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [7:0]    zp;
    logic [15:0]   total;
    logic [15:0]   accepted;
    logic [15:0]   emitted;
    logic          s1_valid;
    logic [SW-1:0] s1_data;
    logic          s2_valid;
    logic [MW-1:0] s2_data;

    logic          s2_adv;
    logic          s2_free;
    logic          s1_adv;
    logic          s1_free;
    logic          accept;
    logic          last_emit;
    logic [W:0]    zp_ext;
    logic [W:0]    lane_d;
    logic [MW-1:0] diff;

    always_comb begin
        s2_adv      = s2_valid && bus.M_Ready;
        s2_free     = !s2_valid || s2_adv;
        s1_adv      = s1_valid && s2_free;
        s1_free     = !s1_valid || s1_adv;
        bus.S_Ready = (state == RUN) && (accepted < total) && s1_free;
        accept      = bus.S_Valid && bus.S_Ready;
        last_emit   = s2_valid && (emitted == total - 16'd1);
    end

    // Zero-extend both operands one bit so the difference spans -255..+255, then sign-extend.
    always_comb begin
        zp_ext = (W+1)'(zp);
        lane_d = '0;
        diff   = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_d = {1'b0, s1_data[k*W +: W]} - zp_ext;
            diff[k*2*W +: 2*W] = {{(W-1){lane_d[W]}}, lane_d};
        end
    end

    assign bus.M_Valid = s2_valid;
    assign bus.M_Data  = s2_data;
    assign bus.M_Last  = last_emit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            zp       <= '0;
            total    <= '0;
            accepted <= '0;
            emitted  <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the previous job's done pulse is dropped.
                    if (start && !done) begin
                        zp       <= zero_data_in;
                        total    <= beat_num;
                        accepted <= '0;
                        emitted  <= '0;
                        if (beat_num == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (s2_adv && last_emit) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase

            if (accept) begin
                accepted <= accepted + 16'd1;
            end
            if (s2_adv) begin
                emitted <= emitted + 16'd1;
            end
            if (s1_free) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= bus.S_Data;
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= diff;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_dezero.sv
// tb/tb_conv_dezero.sv - Directed scoreboard bench for conv_dezero.
`timescale 1ns/1ps

module tb_conv_dezero;
    localparam int P     = 2;
    localparam int C     = 8;
    localparam int LANES = P * C;
    localparam int SW    = LANES * 8;
    localparam int MW    = SW * 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  zero_data_in;
    logic [15:0] beat_num;
    logic        done;
    logic        fixed_rdy;
    logic        rand_mode;
    logic        rnd_rdy;

    int checks;
    int errors;
    int done_cnt;
    logic [7:0] cur_zp;
    logic [MW:0] sb[$];
    logic        hold_prev;
    logic [MW-1:0] prev_data;

    conv_dezero_if #(.PICTURE_NUM(P), .CHANNEL_IN_NUM(C), .WIDTH_DATA(8)) bus ();

    conv_dezero #(.PICTURE_NUM(P), .CHANNEL_IN_NUM(C), .WIDTH_DATA(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .zero_data_in (zero_data_in),
        .beat_num     (beat_num),
        .bus          (bus),
        .done         (done)
    );

    assign bus.M_Ready = rand_mode ? rnd_rdy : fixed_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] model(input logic [SW-1:0] d, input logic [7:0] z);
        logic [MW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            v = int'(d[k*8 +: 8]) - int'(z);
            r[k*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] rnd_beat();
        logic [SW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each handshake and checks hold-stability.
    always @(negedge clk) begin
        logic [MW:0] e;
        if (!rst) begin
            if (done) done_cnt++;
            if (hold_prev) begin
                chk("hold_valid", MW'(bus.M_Valid), MW'(1));
                chk("hold_data", bus.M_Data, prev_data);
            end
            if (bus.M_Valid && bus.M_Ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", MW'(1), MW'(0));
                end else begin
                    e = sb.pop_front();
                    chk("m_data", bus.M_Data, e[MW-1:0]);
                    chk("m_last", MW'(bus.M_Last), MW'(e[MW]));
                end
            end
        end
        hold_prev = !rst && bus.M_Valid && !bus.M_Ready;
        prev_data = bus.M_Data;
    end

    task automatic do_start(input logic [7:0] z, input logic [15:0] n);
        zero_data_in = z;
        beat_num     = n;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic send_beat(input logic [SW-1:0] d, input bit last);
        bit acc;
        acc = 1'b0;
        bus.S_Valid = 1'b1;
        bus.S_Data  = d;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = bus.S_Ready;
            if (acc) sb.push_back({last, model(d, cur_zp)});
            @(posedge clk); #1;
            if (acc) break;
        end
        bus.S_Valid = 1'b0;
        chk("accept_timeout", MW'(acc), MW'(1));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        chk("done_timeout", MW'(seen), MW'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] d;
        int idx;
        int dsnap;
        checks = 0; errors = 0; done_cnt = 0; hold_prev = 1'b0; prev_data = '0;
        rst = 1'b1; start = 1'b0; zero_data_in = '0; beat_num = '0;
        bus.S_Valid = 1'b0; bus.S_Data = '0; fixed_rdy = 1'b1; rand_mode = 1'b0;
        cur_zp = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready", MW'(bus.S_Ready), MW'(0));
        chk("rst_m_valid", MW'(bus.M_Valid), MW'(0));
        chk("rst_m_last", MW'(bus.M_Last), MW'(0));
        chk("rst_done", MW'(done), MW'(0));
        chk("rst_m_data", bus.M_Data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.S_Valid = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", MW'(bus.S_Ready), MW'(0));
        @(posedge clk); #1;
        bus.S_Valid = 1'b0;

        // Single beat, zp=128, boundary lane values
        cur_zp = 8'd128;
        do_start(8'd128, 16'd1);
        d = rnd_beat();
        d[7:0] = 8'd0; d[15:8] = 8'd128; d[23:16] = 8'd255;
        send_beat(d, 1'b1);
        @(negedge clk);
        chk("t34_latency", MW'(bus.M_Valid), MW'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t34_valid", MW'(bus.M_Valid), MW'(1));
        chk("t34_lane0", MW'(bus.M_Data[15:0]), MW'(16'hFF80));
        chk("t34_lane1", MW'(bus.M_Data[31:16]), MW'(16'h0000));
        chk("t34_lane2", MW'(bus.M_Data[47:32]), MW'(16'h007F));
        chk("t34_last", MW'(bus.M_Last), MW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t34_done", MW'(done), MW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t34_done_once", MW'(done), MW'(0));
        @(posedge clk); #1;

        // Four beats streaming: latency 2, full throughput
        cur_zp = 8'd37;
        idx = 0;
        bus.S_Valid = 1'b1;
        d = rnd_beat();
        bus.S_Data = d;
        do_start(8'd37, 16'd4);
        for (int i = 1; i <= 7; i++) begin
            bit acc;
            @(negedge clk);
            chk($sformatf("t35_s_ready_%0d", i), MW'(bus.S_Ready), MW'(i <= 4));
            chk($sformatf("t35_m_valid_%0d", i), MW'(bus.M_Valid), MW'(i >= 3 && i <= 6));
            chk($sformatf("t35_m_last_%0d", i), MW'(bus.M_Last), MW'(i == 6));
            chk($sformatf("t35_done_%0d", i), MW'(done), MW'(i == 7));
            acc = bus.S_Valid && bus.S_Ready;
            if (acc) begin
                sb.push_back({idx == 3, model(d, cur_zp)});
                idx++;
            end
            @(posedge clk); #1;
            if (idx == 4) begin
                bus.S_Valid = 1'b0;
            end else if (acc) begin
                d = rnd_beat();
                bus.S_Data = d;
            end
        end

        // Eight beats under random backpressure
        cur_zp = 8'd7;
        do_start(8'd7, 16'd8);
        rand_mode = 1'b1;
        for (int b = 0; b < 8; b++) send_beat(rnd_beat(), b == 7);
        bus.S_Valid = 1'b1;
        @(negedge clk);
        chk("t36_no_ninth", MW'(bus.S_Ready), MW'(0));
        @(posedge clk); #1;
        bus.S_Valid = 1'b0;
        wait_done();
        rand_mode = 1'b0;
        chk("t36_all_out", MW'(sb.size()), MW'(0));

        // Zero-length job
        bus.S_Valid = 1'b1;
        do_start(8'd50, 16'd0);
        @(negedge clk);
        chk("t37_done", MW'(done), MW'(1));
        chk("t37_m_valid", MW'(bus.M_Valid), MW'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t37_done_once", MW'(done), MW'(0));
        chk("t37_idle", MW'(bus.S_Ready), MW'(0));
        @(posedge clk); #1;
        bus.S_Valid = 1'b0;

        // Reset mid-job, then a clean zp=0 job
        cur_zp = 8'd5;
        do_start(8'd5, 16'd6);
        for (int b = 0; b < 3; b++) send_beat(rnd_beat(), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        dsnap = done_cnt;
        @(negedge clk);
        chk("t38_s_ready", MW'(bus.S_Ready), MW'(0));
        chk("t38_m_valid", MW'(bus.M_Valid), MW'(0));
        chk("t38_m_last", MW'(bus.M_Last), MW'(0));
        chk("t38_done", MW'(done), MW'(0));
        chk("t38_m_data", bus.M_Data, '0);
        repeat (5) @(posedge clk);
        #1;
        chk("t38_no_done", MW'(done_cnt), MW'(dsnap));
        cur_zp = 8'd0;
        do_start(8'd0, 16'd2);
        send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b1);
        wait_done();

        // Start during RUN is ignored
        cur_zp = 8'd10;
        do_start(8'd10, 16'd4);
        send_beat(rnd_beat(), 1'b0);
        do_start(8'd200, 16'd1);
        send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", MW'(sb.size()), MW'(0));
        chk("done_count", MW'(done_cnt), MW'(6));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
